// File: rtl/rp_lsu.sv
// Load/store unit: byte-lane steering, load extension, alignment checks, bus
// handshake with stall and an optional transfer timeout.
module rp_lsu #(
  parameter int XW  = 32,
  parameter int DAW = 32,
  parameter int DDW = 32,
  parameter int DSW = DDW / 8,
  parameter int TMO = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_vld,
  input  logic             req_wen,
  input  logic [DAW-1:0]   req_adr,
  input  logic [1:0]       req_siz,
  input  logic             req_uns,
  input  logic [XW-1:0]    req_wdt,
  output logic             stall,
  output logic             rsp_vld,
  output logic [XW-1:0]    rsp_rdt,
  output logic             mal,
  output logic             err,
  output logic             bud_req,
  output logic             bud_wen,
  output logic [DAW-1:0]   bud_adr,
  output logic [DSW-1:0]   bud_sel,
  output logic [DSW*8-1:0] bud_wdt,
  input  logic [DSW*8-1:0] bud_rdt,
  input  logic             bud_ack
);

  localparam int OW = $clog2(DSW);
  localparam int BW = $clog2(XW / 8);
  localparam int CW = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [CW-1:0] TLAST = CW'(TMO - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            cap_wen_reg;
  logic [DAW-1:0]  cap_adr_reg;
  logic [1:0]      cap_siz_reg;
  logic            cap_uns_reg;
  logic [XW-1:0]   cap_wdt_reg;

  logic            busy;
  logic            cur_wen;
  logic [DAW-1:0]  cur_adr;
  logic [1:0]      cur_siz;
  logic            cur_uns;
  logic [XW-1:0]   cur_wdt;
  logic [OW-1:0]   off;
  logic [2:0]      amask;
  logic            legal;
  logic            go;
  logic            mal_c;
  logic            active;
  logic [CW-1:0]   cnt_eff;
  logic            tmo_hit;

  // While BUSY the captured request drives the bus; in IDLE the live one does.
  assign busy    = (state_reg == BUSY);
  assign cur_wen = busy ? cap_wen_reg : req_wen;
  assign cur_adr = busy ? cap_adr_reg : req_adr;
  assign cur_siz = busy ? cap_siz_reg : req_siz;
  assign cur_uns = busy ? cap_uns_reg : req_uns;
  assign cur_wdt = busy ? cap_wdt_reg : req_wdt;
  assign off     = cur_adr[OW-1:0];

  always_comb begin
    case (cur_siz)
      2'd0:    amask = 3'd0;
      2'd1:    amask = 3'd1;
      2'd2:    amask = 3'd3;
      default: amask = 3'd7;
    endcase
  end

  assign legal   = (cur_siz <= 2'(BW)) && ((cur_adr[2:0] & amask) == 3'd0);
  assign go      = !busy && req_vld && legal;
  assign mal_c   = !busy && req_vld && !legal;
  assign active  = busy || go;
  assign cnt_eff = busy ? cnt_reg : '0;
  assign tmo_hit = (TMO != 0) && (cnt_eff == TLAST) && !bud_ack;

  // State register and request capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      cap_wen_reg <= 1'b0;
      cap_adr_reg <= '0;
      cap_siz_reg <= 2'd0;
      cap_uns_reg <= 1'b0;
      cap_wdt_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (!busy && state_next == BUSY) begin
        cap_wen_reg <= req_wen;
        cap_adr_reg <= req_adr;
        cap_siz_reg <= req_siz;
        cap_uns_reg <= req_uns;
        cap_wdt_reg <= req_wdt;
      end
    end
  end

  // Next state; the counter includes the request cycle, so BUSY starts at 1.
  always_comb begin
    state_next = state_reg;
    cnt_next   = '0;
    case (state_reg)
      IDLE: begin
        if (go && !bud_ack && !tmo_hit) begin
          state_next = BUSY;
          cnt_next   = CW'(1);
        end
      end
      BUSY: begin
        if (bud_ack || tmo_hit) state_next = IDLE;
        else                    cnt_next   = cnt_reg + 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  logic [DSW-1:0]   sel_base;
  logic [DSW*8-1:0] wdt_rep;
  logic [BW-1:0]    bi;
  logic [DSW*8-1:0] rdt_shift;
  logic [XW-1:0]    rdt_low;
  logic [XW-1:0]    rdt_ext;
  logic [6:0]       nbits;
  logic             sgn;

  always_comb begin
    case (cur_siz)
      2'd0:    sel_base = DSW'(8'h01);
      2'd1:    sel_base = DSW'(8'h03);
      2'd2:    sel_base = DSW'(8'h0F);
      default: sel_base = DSW'(8'hFF);
    endcase
  end

  // Each lane takes the request byte at (lane mod access size).
  always_comb begin
    wdt_rep = '0;
    bi      = '0;
    for (int i = 0; i < DSW; i++) begin
      bi = BW'(i) & amask[BW-1:0];
      wdt_rep[8*i +: 8] = cur_wdt[{bi, 3'b000} +: 8];
    end
  end

  assign rdt_shift = bud_rdt >> {off, 3'b000};
  assign rdt_low   = rdt_shift[XW-1:0];
  assign nbits     = 7'd8 << cur_siz;

  always_comb begin
    case (cur_siz)
      2'd0:    sgn = rdt_low[7];
      2'd1:    sgn = rdt_low[15];
      2'd2:    sgn = rdt_low[31];
      default: sgn = rdt_low[XW-1];
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < XW; gi++) begin : g_ext
      assign rdt_ext[gi] = (7'(gi) < nbits) ? rdt_low[gi] : (!cur_uns && sgn);
    end
  endgenerate

  // Outputs; held at zero while reset is asserted, independent of the clock.
  always_comb begin
    stall   = 1'b0;
    rsp_vld = 1'b0;
    rsp_rdt = '0;
    mal     = 1'b0;
    err     = 1'b0;
    bud_req = 1'b0;
    bud_wen = 1'b0;
    bud_adr = '0;
    bud_sel = '0;
    bud_wdt = '0;
    if (rst) begin
      bud_req = active && !tmo_hit;
      rsp_vld = active && bud_ack;
      stall   = active && !bud_ack && !tmo_hit;
      err     = active && tmo_hit;
      mal     = mal_c;
      bud_adr = {cur_adr[DAW-1:OW], {OW{1'b0}}};
      bud_wdt = wdt_rep;
      if (bud_req) begin
        bud_wen = cur_wen;
        bud_sel = sel_base << off;
      end
      if (rsp_vld && !cur_wen) rsp_rdt = rdt_ext;
    end
  end

endmodule
